// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, counter types and the
// stripe colour helper shared by the stripe generator and its counters.
package vga_timing_pkg;

  // Horizontal timing in pixels.
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOT    = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  // Vertical timing in lines.
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOT    = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // 64-pixel stripes by default.
  localparam int VGA_STRIPE_LOG2 = 6;

  // Counter widths; 10 bits covers both 800 and 525.
  localparam int H_W = 10;
  localparam int V_W = 10;

  typedef logic [H_W-1:0] hcnt_t;
  typedef logic [V_W-1:0] vcnt_t;

  // {R,G,B}: index 0 is black, index 7 is white.
  typedef logic [2:0] color_t;

  // Stripe number of a pixel plus the scroll offset, wrapping mod 8.
  function automatic color_t stripe_color(hcnt_t h, int log2w, color_t off);
    return color_t'(h >> log2w) + off;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: pixel/line counters gated by pix_en, registered sync and
// video_on decode, a combinational active-area flag for the colour path and
// the frame-wrap strobe.
module vga_sync_counter
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic  clk1,
  input  logic  rst_n,
  input  logic  pix_en,
  output hcnt_t h_cnt_o,
  output logic  active_o,
  output logic  hsync_o,
  output logic  vsync_o,
  output logic  video_on_o,
  output logic  wrap_o
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO = H_ACTIVE + H_FP;
  localparam int HS_HI = HS_LO + H_SYNC - 1;
  localparam int VS_LO = V_ACTIVE + V_FP;
  localparam int VS_HI = VS_LO + V_SYNC - 1;

  hcnt_t h_cnt_q, h_cnt_d;
  vcnt_t v_cnt_q, v_cnt_d;
  logic  hsync_q, hsync_d;
  logic  vsync_q, vsync_d;
  logic  video_on_q, video_on_d;
  logic  h_last, v_last;
  logic  hs_win, vs_win, active;

  assign h_last = (h_cnt_q == hcnt_t'(H_TOT - 1));
  assign v_last = (v_cnt_q == vcnt_t'(V_TOT - 1));

  assign hs_win = (h_cnt_q >= hcnt_t'(HS_LO)) && (h_cnt_q <= hcnt_t'(HS_HI));
  assign vs_win = (v_cnt_q >= vcnt_t'(VS_LO)) && (v_cnt_q <= vcnt_t'(VS_HI));
  assign active = (h_cnt_q < hcnt_t'(H_ACTIVE)) && (v_cnt_q < vcnt_t'(V_ACTIVE));

  // Counter advance and output decode; everything holds while pix_en is low.
  always_comb begin
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    video_on_d = video_on_q;
    if (pix_en) begin
      // Decode uses the pre-increment position, so outputs trail by one pixel.
      hsync_d    = ~hs_win;
      vsync_d    = ~vs_win;
      video_on_d = active;
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + vcnt_t'(1);
      end else begin
        h_cnt_d = h_cnt_q + hcnt_t'(1);
      end
    end
  end

  // State and registered sync outputs.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
    end
  end

  assign h_cnt_o    = h_cnt_q;
  assign active_o   = active;
  assign hsync_o    = hsync_q;
  assign vsync_o    = vsync_q;
  assign video_on_o = video_on_q;
  assign wrap_o     = pix_en & h_last & v_last;

endmodule

// File: rtl/vga_stripe_gen.sv
// vga_stripe_gen: 640x480@60 VGA sync plus vertical colour bars that scroll
// one stripe per edge of the slow step_in toggle. Scrolling only takes effect
// at frame wrap so a frame is never torn.
// Build option: define VGA_STRIPE_SCROLL_EN to enable scrolling; without it
// the offset is fixed at 0 and step_in is ignored.
module vga_stripe_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int H_FP        = VGA_H_FP,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BP        = VGA_H_BP,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int V_FP        = VGA_V_FP,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BP        = VGA_V_BP,
  parameter int STRIPE_LOG2 = VGA_STRIPE_LOG2
) (
  input  logic   clk1,
  input  logic   rst_n,
  input  logic   pix_en,
  input  logic   step_in,
  output logic   hsync,
  output logic   vsync,
  output logic   video_on,
  output color_t rgb,
  output logic   frame_tick
);

  hcnt_t  h_cnt;
  logic   active;
  logic   wrap;
  color_t offset;
  color_t rgb_q, rgb_d;
  logic   frame_tick_q;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_cnt (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .pix_en     (pix_en),
    .h_cnt_o    (h_cnt),
    .active_o   (active),
    .hsync_o    (hsync),
    .vsync_o    (vsync),
    .video_on_o (video_on),
    .wrap_o     (wrap)
  );

`ifdef VGA_STRIPE_SCROLL_EN
  // sync_q[0]/[1] are the synchronizer, sync_q[2] remembers the previous
  // synchronized value for edge detection.
  logic [2:0] sync_q;
  logic       step_evt;
  logic       pending_q, pending_d;
  color_t     offset_q, offset_d;

  assign step_evt = sync_q[1] ^ sync_q[2];

  // Synchronizer runs every clk1 cycle regardless of pix_en.
  always_ff @(posedge clk1) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], step_in};
  end

  // Collect step events during the frame and apply at most one at wrap;
  // an event landing on the wrap cycle itself is applied immediately.
  always_comb begin
    pending_d = pending_q;
    offset_d  = offset_q;
    if (wrap) begin
      if (pending_q || step_evt) offset_d = offset_q + color_t'(1);
      pending_d = 1'b0;
    end else if (step_evt) begin
      pending_d = 1'b1;
    end
  end

  // Pending flag and scroll offset registers.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      offset_q  <= '0;
    end else begin
      pending_q <= pending_d;
      offset_q  <= offset_d;
    end
  end

  assign offset = offset_q;
`else
  logic unused_step;

  assign unused_step = step_in;
  assign offset      = '0;
`endif

  // Colour for the current pixel, black outside the active area.
  always_comb begin
    rgb_d = rgb_q;
    if (pix_en) rgb_d = active ? stripe_color(h_cnt, STRIPE_LOG2, offset) : '0;
  end

  // Registered colour (aligned with the sync outputs) and frame tick.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      rgb_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      rgb_q        <= rgb_d;
      frame_tick_q <= wrap;
    end
  end

  assign rgb        = rgb_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_stripe_gen.sv
// tb_vga_stripe_gen: randomized bench with a pixel-position reference model
// and a scoreboard queue. Uses a shrunken raster so whole frames fit in a
// short run; the same rules apply at any size.
module tb_vga_stripe_gen;

  localparam int HA = 40, HF = 4, HS = 6, HB = 6;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int SL = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

`ifdef VGA_STRIPE_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  logic       clk1 = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_en = 1'b0;
  logic       step_in = 1'b0;
  logic       hsync, vsync, video_on, frame_tick;
  logic [2:0] rgb;

  always #5 clk1 = ~clk1;

  vga_stripe_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .STRIPE_LOG2 (SL)
  ) dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .pix_en     (pix_en),
    .step_in    (step_in),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .rgb        (rgb),
    .frame_tick (frame_tick)
  );

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic [2:0] rgb;
    logic       ft;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errs = 0;

  // Reference model: n is the linear pixel index in the frame, off the
  // scroll offset, pend "some step seen this frame", samp the last three
  // values sampled from step_in (samp[0] newest).
  int   n = 0;
  int   off = 0;
  bit   pend = 1'b0;
  bit   samp[3] = '{0, 0, 0};
  int   frames = 0;
  exp_t cur = '{hs: 1'b1, vs: 1'b1, von: 1'b0, rgb: 3'd0, ft: 1'b0};

  task automatic model_edge();
    int x, y;
    bit wrap, evt;
    if (!rst_n) begin
      n = 0; off = 0; pend = 1'b0;
      samp = '{0, 0, 0};
      cur = '{hs: 1'b1, vs: 1'b1, von: 1'b0, rgb: 3'd0, ft: 1'b0};
    end else begin
      // A step_in change shows up as an event three samples later.
      evt  = SCROLL && (samp[1] != samp[2]);
      wrap = pix_en && (n == FT - 1);
      cur.ft = wrap;
      if (pix_en) begin
        x = n % HT;
        y = n / HT;
        cur.hs  = !(x >= HA + HF && x < HA + HF + HS);
        cur.vs  = !(y >= VA + VF && y < VA + VF + VS);
        cur.von = (x < HA) && (y < VA);
        cur.rgb = cur.von ? 3'(((x >> SL) + off) % 8) : 3'd0;
        n = (n + 1) % FT;
      end
      if (wrap) begin
        if (pend || evt) off = (off + 1) % 8;
        pend = 1'b0;
        frames++;
      end else if (evt) begin
        pend = 1'b1;
      end
      samp[2] = samp[1];
      samp[1] = samp[0];
      samp[0] = step_in;
    end
    q.push_back(cur);
  endtask

  // One clk1 cycle: apply inputs, let the edge happen, record expectation.
  task automatic cyc(input bit pe, input bit rs);
    pix_en = pe;
    rst_n  = rs;
    @(posedge clk1);
    #1;
    model_edge();
  endtask

  task automatic run_rand(input int cycles, input int pe_pct);
    for (int i = 0; i < cycles; i++) cyc($urandom_range(99) < pe_pct, 1'b1);
  endtask

  task automatic run_frames(input int f, input int pe_pct);
    int target, g;
    target = frames + f;
    g = 0;
    while (frames < target && g < 4 * FT * f) begin
      cyc($urandom_range(99) < pe_pct, 1'b1);
      g++;
    end
  endtask

  task automatic wait_pos(input int target, input int pe_pct);
    int g;
    g = 0;
    while (n != target && g < 4 * FT) begin
      cyc($urandom_range(99) < pe_pct, 1'b1);
      g++;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents a registered output set.
  always @(negedge clk1) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("hsync",      int'(hsync),      int'(e.hs));
      chk("vsync",      int'(vsync),      int'(e.vs));
      chk("video_on",   int'(video_on),   int'(e.von));
      chk("rgb",        int'(rgb),        int'(e.rgb));
      chk("frame_tick", int'(frame_tick), int'(e.ft));
    end
  end

  initial begin
    // Reset for 5 cycles with pix_en every 2nd cycle.
    for (int i = 0; i < 5; i++) cyc(i % 2 == 1, 1'b0);

    // Free-run two frames with sparse pix_en, step_in idle.
    run_frames(2, 70);

    // Single toggle mid-frame, then watch the next frames.
    wait_pos(FT / 2, 70);
    step_in = ~step_in;
    run_frames(2, 80);

    // Three toggles inside one frame collapse into one step.
    wait_pos(HT * 2, 80);
    for (int k = 0; k < 3; k++) begin
      step_in = ~step_in;
      run_rand(8, 80);
    end
    run_frames(2, 80);

    // Step event landing exactly on the wrap cycle.
    wait_pos(FT - 3, 80);
    step_in = ~step_in;
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1);
    run_frames(2, 90);

    // Scroll towards offset 5, then reset mid-frame.
    for (int k = 0; k < 8 && (!SCROLL || off != 5); k++) begin
      wait_pos(FT / 2, 90);
      step_in = ~step_in;
      run_frames(1, 90);
    end
    wait_pos(HT * (VA / 2) + 30, 90);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    run_frames(1, 90);

    // Random pix_en density and random step toggles.
    for (int i = 0; i < 9000; i++) begin
      if ($urandom_range(299) == 0) step_in = ~step_in;
      cyc($urandom_range(99) < 60, 1'b1);
    end

    repeat (3) @(negedge clk1);
    chk("scoreboard_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
